// File: rtl/usb_utm_line_mon.sv
// usb_utm_line_mon: deglitches UTM line_state and reports bus reset, suspend, resume and SE1
module usb_utm_line_mon #(
    parameter int FILT_CYCLES    = 4,
    parameter int RESET_CYCLES   = 150,
    parameter int SUSPEND_CYCLES = 180000,
    parameter bit LOW_SPEED      = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] line_state,
    input  logic [1:0] op_mode,
    output logic [1:0] filt_state,
    output logic       bus_reset,
    output logic       bus_reset_start,
    output logic       suspend,
    output logic       suspend_start,
    output logic       resume,
    output logic       se1_err
);
    localparam int TMR_MAX = (RESET_CYCLES > SUSPEND_CYCLES) ? RESET_CYCLES : SUSPEND_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int STAB_W  = $clog2(FILT_CYCLES + 1);
    localparam logic [1:0] LS_SE0 = 2'b00, LS_J = 2'b01, LS_K = 2'b10, LS_SE1 = 2'b11;
    localparam logic [1:0] OM_DISABLE = 2'b10;
    localparam logic [1:0] ST_ACTIVE = 2'b00, ST_RESET = 2'b01, ST_SUSPEND = 2'b10, ST_RESUME = 2'b11;

    logic [1:0]        ls_in, line_q, state, state_nxt;
    logic [STAB_W-1:0] stab_cnt;
    logic [TMR_W-1:0]  timer;
    logic              same, filt_upd, frozen, se0_held, j_held;

    // LS devices see J/K swapped on the wire; flip them so filt_state is always in device terms
    assign ls_in    = (LOW_SPEED && (line_state[0] ^ line_state[1])) ? ~line_state : line_state;
    assign same     = ls_in == line_q;
    // accept on the edge where the stability count reaches FILT_CYCLES
    assign filt_upd = same && (32'(stab_cnt) >= FILT_CYCLES - 1) && line_q != filt_state;
    assign frozen   = op_mode == OM_DISABLE;
    assign se0_held = filt_state == LS_SE0 && 32'(timer) + 1 >= RESET_CYCLES;
    assign j_held   = filt_state == LS_J && 32'(timer) + 1 >= SUSPEND_CYCLES;
    assign bus_reset = state == ST_RESET;
    assign suspend   = state == ST_SUSPEND;

    // input register, stability counter and filtered line state
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q     <= LS_SE0;
            stab_cnt   <= '0;
            filt_state <= LS_SE0;
            se1_err    <= 1'b0;
        end else begin
            line_q     <= ls_in;
            stab_cnt   <= !same ? '0 : (32'(stab_cnt) < FILT_CYCLES) ? stab_cnt + STAB_W'(1) : stab_cnt;
            filt_state <= filt_upd ? line_q : filt_state;
            se1_err    <= filt_upd && line_q == LS_SE1;
        end
    end

    // saturating age of the current filtered state; held at 0 while timing is disabled
    always_ff @(posedge clk) begin
        if (rst || frozen || filt_upd)
            timer <= '0;
        else if (timer != '1)
            timer <= timer + TMR_W'(1);
    end

    // bus condition state machine; frozen in DISABLE so no transitions or pulses occur
    always_comb begin
        state_nxt = state;
        if (!frozen)
            case (state)
                ST_ACTIVE:  state_nxt = se0_held ? ST_RESET : j_held ? ST_SUSPEND : ST_ACTIVE;
                ST_RESET:   state_nxt = filt_state != LS_SE0 ? ST_ACTIVE : ST_RESET;
                ST_SUSPEND: state_nxt = filt_state == LS_K ? ST_RESUME : se0_held ? ST_RESET : ST_SUSPEND;
                default:    state_nxt = filt_state == LS_J ? ST_ACTIVE : se0_held ? ST_RESET : ST_RESUME;
            endcase
    end

    // state register and entry pulses; one transition per edge keeps pulses mutually exclusive
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_ACTIVE;
            bus_reset_start <= 1'b0;
            suspend_start   <= 1'b0;
            resume          <= 1'b0;
        end else begin
            state           <= state_nxt;
            bus_reset_start <= state_nxt == ST_RESET && state != ST_RESET;
            suspend_start   <= state_nxt == ST_SUSPEND && state != ST_SUSPEND;
            resume          <= state_nxt == ST_RESUME && state == ST_SUSPEND;
        end
    end
endmodule

// File: tb/tb_usb_utm_line_mon.sv
// tb_usb_utm_line_mon: directed stimulus with an event scoreboard for usb_utm_line_mon
module tb_usb_utm_line_mon;
    localparam logic [1:0] SE0 = 2'b00, J = 2'b01, K = 2'b10, SE1 = 2'b11, DIS = 2'b10;
    localparam logic [3:0] BRS = 4'b1000, SS = 4'b0100, RS = 4'b0010, SE = 4'b0001;

    typedef struct packed {
        int         c;
        logic [1:0] f;
        logic       br;
        logic       sus;
        logic [3:0] p;
    } ev_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic [1:0] line_state = J, op_mode = 2'b00;
    logic [1:0] filt_state, ls_filt;
    logic       bus_reset, bus_reset_start, suspend, suspend_start, resume, se1_err;
    logic       ls_br, ls_brs, ls_sus, ls_ss, ls_res, ls_se1;
    logic [1:0] pf = 2'b00;
    logic       pbr = 1'b0, psus = 1'b0;
    int         cyc = 0, checks = 0, failures = 0, base = 0;
    ev_t        q[$];

    usb_utm_line_mon #(.FILT_CYCLES(2), .RESET_CYCLES(20), .SUSPEND_CYCLES(100), .LOW_SPEED(1'b0)) dut (
        .clk(clk), .rst(rst), .line_state(line_state), .op_mode(op_mode),
        .filt_state(filt_state), .bus_reset(bus_reset), .bus_reset_start(bus_reset_start),
        .suspend(suspend), .suspend_start(suspend_start), .resume(resume), .se1_err(se1_err)
    );

    usb_utm_line_mon #(.FILT_CYCLES(2), .RESET_CYCLES(20), .SUSPEND_CYCLES(100), .LOW_SPEED(1'b1)) dut_ls (
        .clk(clk), .rst(rst), .line_state(line_state), .op_mode(op_mode),
        .filt_state(ls_filt), .bus_reset(ls_br), .bus_reset_start(ls_brs),
        .suspend(ls_sus), .suspend_start(ls_ss), .resume(ls_res), .se1_err(ls_se1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp(input int dc, input logic [1:0] f, input logic br, input logic sus, input logic [3:0] p);
        q.push_back(ev_t'{base + dc, f, br, sus, p});
    endtask

    task automatic to_cyc(input int dc);
        while (cyc < base + dc) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc - base);
        end
    endtask

    // monitor: every visible output event is matched against the next expected one
    always @(negedge clk) begin
        ev_t a, e;
        a = ev_t'{cyc, filt_state, bus_reset, suspend, {bus_reset_start, suspend_start, resume, se1_err}};
        if (a.f != pf || a.br != pbr || a.sus != psus || a.p != 4'b0) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL event: unexpected cyc=%0d filt=%b br=%b sus=%b p=%b",
                         a.c - base, a.f, a.br, a.sus, a.p);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL event: got cyc=%0d filt=%b br=%b sus=%b p=%b want cyc=%0d filt=%b br=%b sus=%b p=%b",
                             a.c - base, a.f, a.br, a.sus, a.p, e.c - base, e.f, e.br, e.sus, e.p);
                end
            end
        end
        pf   = a.f;
        pbr  = a.br;
        psus = a.sus;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_filt", 32'(filt_state), 0);
        chk("rst_levels", {bus_reset, suspend}, 0);
        chk("rst_pulses", {bus_reset_start, suspend_start, resume, se1_err}, 0);
        rst  = 1'b0;
        base = cyc;
        exp(3, J, 0, 0, 0);
        to_cyc(10);  line_state = K;
        to_cyc(11);  line_state = J;
        exp(103, J, 0, 1, SS);
        to_cyc(110); line_state = K;
        exp(113, K, 0, 1, 0);
        exp(114, K, 0, 0, RS);
        to_cyc(120); line_state = SE0;
        exp(123, SE0, 0, 0, 0);
        to_cyc(124); line_state = J;
        exp(127, J, 0, 0, 0);
        exp(227, J, 0, 1, SS);
        to_cyc(230); line_state = SE0;
        exp(233, SE0, 0, 1, 0);
        exp(253, SE0, 1, 0, BRS);
        to_cyc(260); line_state = J;
        exp(263, J, 1, 0, 0);
        exp(264, J, 0, 0, 0);
        to_cyc(270); line_state = SE0;
        exp(273, SE0, 0, 0, 0);
        exp(293, SE0, 1, 0, BRS);
        to_cyc(300); line_state = J;
        exp(303, J, 1, 0, 0);
        exp(304, J, 0, 0, 0);
        to_cyc(310); line_state = SE1;
        exp(313, SE1, 0, 0, SE);
        to_cyc(314); chk("ls_se1", 32'(ls_filt), 32'(SE1));
        to_cyc(315); line_state = J;
        exp(318, J, 0, 0, 0);
        to_cyc(320); op_mode = DIS; line_state = K;
        exp(323, K, 0, 0, 0);
        to_cyc(400); chk("ls_raw10_is_j", 32'(ls_filt), 32'(J));
        to_cyc(520); op_mode = 2'b00; line_state = J;
        exp(523, J, 0, 0, 0);
        to_cyc(526); chk("ls_raw01_is_k", 32'(ls_filt), 32'(K));
        to_cyc(530); op_mode = DIS; line_state = SE0;
        exp(533, SE0, 0, 0, 0);
        to_cyc(570); op_mode = 2'b00;
        exp(590, SE0, 1, 0, BRS);
        to_cyc(595); chk("reset_level", 32'(bus_reset), 1);
        to_cyc(600); rst = 1'b1; line_state = J;
        exp(601, SE0, 0, 0, 0);
        to_cyc(602);
        chk("midrst_filt", 32'(filt_state), 0);
        chk("midrst_out", {bus_reset, suspend, bus_reset_start, suspend_start, resume, se1_err}, 0);
        to_cyc(603); rst = 1'b0;
        exp(606, J, 0, 0, 0);
        to_cyc(650);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
